// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_pkg;

    // Frame-level controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } conv_state_t;

    localparam int PIX_W = 8;
    localparam int KWIN  = 3;
    localparam int VEC_W = 72;

    // Number of valid (unpadded) 3x3 output positions in a w x h frame.
    function automatic logic [15:0] out_total(input int w, input int h);
        return 16'((w - 2) * (h - 2));
    endfunction

    // Shift the packed window left one column and insert a new right column.
    // Byte k = KWIN*r + c; c = 0 is the oldest column, r = 0 the top row.
    function automatic logic [VEC_W-1:0] shift_in_column(
        input logic [VEC_W-1:0] win,
        input logic [PIX_W-1:0] top,
        input logic [PIX_W-1:0] mid,
        input logic [PIX_W-1:0] bot
    );
        logic [VEC_W-1:0] res;
        logic [PIX_W-1:0] col_new [KWIN];
        col_new[0] = top;
        col_new[1] = mid;
        col_new[2] = bot;
        res = win;
        for (int r = 0; r < KWIN; r++) begin
            for (int c = 0; c < KWIN - 1; c++) begin
                res[(KWIN*r + c)*PIX_W +: PIX_W] = win[(KWIN*r + c + 1)*PIX_W +: PIX_W];
            end
            res[(KWIN*r + KWIN - 1)*PIX_W +: PIX_W] = col_new[r];
        end
        return res;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: asynchronous read, synchronous write to the same
// address, so a read in the write cycle returns the old (previous-row) value.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Contents are never cleared; rows are fully rewritten before they are used.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Builds sliding 3x3 windows from a row-major pixel stream and tracks the
// engine's result strobes to detect frame completion.
//
// Handshake: a pixel is transferred on a rising edge where s_valid and
// s_ready are both high; s_ready depends only on the FSM state (high only in
// STREAM), and s_valid may drop at any time without disturbing the window.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [PIX_W-1:0]  s_pixel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [VEC_W-1:0]  img_vector,
    output logic              img_vector_valid,
    input  logic              eng_pixel_valid,
    output logic [15:0]       out_count,
    output conv_state_t       dbg_state_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [15:0]   TOTAL    = out_total(IMG_W, IMG_H);

    conv_state_t      state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [VEC_W-1:0] win_q, win_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             vld_q, vld_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic             accept;
    logic             last_pix;
    logic             clear;
    logic             counting;

    assign accept   = s_valid && (state_q == ST_STREAM);
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign clear    = (state_q == ST_IDLE) && start;
    assign counting = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

    // lb0 holds the previous row, lb1 the row before it.
    line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (s_pixel),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Datapath next-state: counters, window shift, emission and result count.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        win_d = win_q;
        vec_d = vec_q;
        vld_d = 1'b0;
        cnt_d = cnt_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            win_d = '0;
            cnt_d = '0;
        end
        if (accept) begin
            win_d = shift_in_column(win_q, lb1_rd, lb0_rd, s_pixel);
            // Stale columns from the previous row are shifted out by col 2.
            if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
                vec_d = win_d;
                vld_d = 1'b1;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (eng_pixel_valid && counting) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // FSM next-state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (accept && last_pix) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Use the post-increment count so the final strobe ends DRAIN at once.
                if (cnt_d == TOTAL) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= '0;
            vec_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign img_vector       = vec_q;
    assign img_vector_valid = vld_q;
    assign out_count        = cnt_q;
    assign dbg_state_o      = state_q;

endmodule
